// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, forwarding selects, MUL FSM states.
package ex_pkg;

    localparam int ALUFN_W = 3;
    localparam int FWD_W   = 2;

    localparam logic [ALUFN_W-1:0] ALU_ADD = 3'd0;
    localparam logic [ALUFN_W-1:0] ALU_SUB = 3'd1;
    localparam logic [ALUFN_W-1:0] ALU_AND = 3'd2;
    localparam logic [ALUFN_W-1:0] ALU_OR  = 3'd3;
    localparam logic [ALUFN_W-1:0] ALU_XOR = 3'd4;
    localparam logic [ALUFN_W-1:0] ALU_SLT = 3'd5;
    localparam logic [ALUFN_W-1:0] ALU_SHL = 3'd6;
    localparam logic [ALUFN_W-1:0] ALU_MUL = 3'd7;

    localparam logic [FWD_W-1:0] FWD_REG   = 2'd0;
    localparam logic [FWD_W-1:0] FWD_EXMEM = 2'd1;
    localparam logic [FWD_W-1:0] FWD_MEMWB = 2'd2;

    typedef enum logic {
        MUL_IDLE = 1'b0,
        MUL_BUSY = 1'b1
    } mul_state_e;

endpackage

// File: rtl/ex_stage_l3_seq_mul_unit.sv
// Iterative shift-add multiplier: one partial product per cycle, DATA_W cycles after load.
// done marks the final step; product is that step's accumulator value (low DATA_W bits).
module seq_mul_unit
    import ex_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk2,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    mul_state_e        state;
    logic [DATA_W-1:0] mcand, mplier, acc, acc_next;
    logic [CNT_W-1:0]  cnt;

    assign acc_next = mplier[0] ? acc + mcand : acc;
    assign busy     = (state == MUL_BUSY);
    assign done     = busy && (cnt == LAST);
    assign product  = acc_next;

    always_ff @(posedge clk2) begin
        if (!rst_n) begin
            state  <= MUL_IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (abort) begin
            state <= MUL_IDLE;
        end else begin
            case (state)
                MUL_IDLE: begin
                    if (start) begin
                        mcand  <= op_a;
                        mplier <= op_b;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= MUL_BUSY;
                    end
                end
                MUL_BUSY: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) state <= MUL_IDLE;
                end
                default: state <= MUL_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ex_stage_l3.sv
// Execute stage: operand forwarding, single-cycle ALU and EX/MEM register.
// EX_MUL_EN enables the iterative multiplier for alufn 7; otherwise MUL yields 0 in one cycle.
module ex_stage_l3
    import ex_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int RADDR_W = 3
) (
    input  logic               clk2,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  imm_in,
    input  logic [DATA_W-1:0]  a_in,
    input  logic [DATA_W-1:0]  b_in,
    input  logic [FWD_W-1:0]   fwd_a_sel,
    input  logic [FWD_W-1:0]   fwd_b_sel,
    input  logic [DATA_W-1:0]  exmem_fwd,
    input  logic [DATA_W-1:0]  memwb_fwd,
    input  logic               alusrc_in,
    input  logic [ALUFN_W-1:0] alufn_in,
    input  logic               memwrite_in,
    input  logic               memread_in,
    input  logic               memtoreg_in,
    input  logic               regwrite_in,
    input  logic [RADDR_W-1:0] regwradd_in,
    input  logic               flush,
    output logic               stall_o,
    output logic               out_valid,
    output logic [DATA_W-1:0]  alu_result,
    output logic [DATA_W-1:0]  store_data,
    output logic               zero,
    output logic               memwrite_o,
    output logic               memread_o,
    output logic               memtoreg_o,
    output logic               regwrite_o,
    output logic [RADDR_W-1:0] regwradd_o
);

    logic [DATA_W-1:0] op1, fwd_b, op2, alu_y, res;
    logic              ld_instr;

    function automatic logic [DATA_W-1:0] fwd_mux(input logic [FWD_W-1:0] sel,
                                                  input logic [DATA_W-1:0] r,
                                                  input logic [DATA_W-1:0] ex,
                                                  input logic [DATA_W-1:0] mw);
        case (sel)
            FWD_EXMEM: return ex;
            FWD_MEMWB: return mw;
            default:   return r;
        endcase
    endfunction

    assign op1   = fwd_mux(fwd_a_sel, a_in, exmem_fwd, memwb_fwd);
    assign fwd_b = fwd_mux(fwd_b_sel, b_in, exmem_fwd, memwb_fwd);
    assign op2   = alusrc_in ? imm_in : fwd_b;

    always_comb begin
        alu_y = '0;
        case (alufn_in)
            ALU_ADD: alu_y = op1 + op2;
            ALU_SUB: alu_y = op1 - op2;
            ALU_AND: alu_y = op1 & op2;
            ALU_OR:  alu_y = op1 | op2;
            ALU_XOR: alu_y = op1 ^ op2;
            ALU_SLT: alu_y = {{(DATA_W-1){1'b0}}, ($signed(op1) < $signed(op2))};
            ALU_SHL: alu_y = op1 << op2[2:0];
            default: alu_y = '0;
        endcase
    end

`ifdef EX_MUL_EN
    logic              is_mul, mul_start, mul_busy, mul_done;
    logic [DATA_W-1:0] mul_prod;

    assign is_mul    = in_valid && (alufn_in == ALU_MUL);
    assign mul_start = is_mul && !mul_busy && !flush;

    seq_mul_unit #(.DATA_W(DATA_W)) u_mul (
        .clk2    (clk2),
        .rst_n   (rst_n),
        .start   (mul_start),
        .abort   (flush),
        .op_a    (op1),
        .op_b    (op2),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_prod)
    );

    // Release the stall on the final step so upstream advances on the completion edge.
    assign stall_o = rst_n && !flush && (mul_start || (mul_busy && !mul_done));

    always_comb begin
        ld_instr = in_valid;
        res      = alu_y;
        if (mul_busy) begin
            ld_instr = mul_done;
            res      = mul_prod;
        end else if (is_mul) begin
            ld_instr = 1'b0;
        end
    end
`else
    assign stall_o = 1'b0;

    always_comb begin
        ld_instr = in_valid;
        res      = alu_y;
    end
`endif

    always_ff @(posedge clk2) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            alu_result <= '0;
            store_data <= '0;
            zero       <= 1'b0;
            memwrite_o <= 1'b0;
            memread_o  <= 1'b0;
            memtoreg_o <= 1'b0;
            regwrite_o <= 1'b0;
            regwradd_o <= '0;
        end else if (flush || !ld_instr) begin
            // Bubble: kill side effects, leave data fields as they were.
            out_valid  <= 1'b0;
            memwrite_o <= 1'b0;
            memread_o  <= 1'b0;
            memtoreg_o <= 1'b0;
            regwrite_o <= 1'b0;
        end else begin
            out_valid  <= 1'b1;
            alu_result <= res;
            store_data <= fwd_b;
            zero       <= (res == '0);
            memwrite_o <= memwrite_in;
            memread_o  <= memread_in;
            memtoreg_o <= memtoreg_in;
            regwrite_o <= regwrite_in;
            regwradd_o <= regwradd_in;
        end
    end

endmodule

// File: tb/tb_ex_stage_l3.sv
// Self-checking bench for ex_stage_l3: directed steps plus randomized instructions against a
// reference model; follows EX_MUL_EN the same way the design does.
module tb_ex_stage_l3;

    logic       clk2 = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] imm_in, a_in, b_in, exmem_fwd, memwb_fwd;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic       alusrc_in;
    logic [2:0] alufn_in;
    logic       memwrite_in, memread_in, memtoreg_in, regwrite_in;
    logic [2:0] regwradd_in;
    logic       flush;
    logic       stall_o, out_valid, zero;
    logic [7:0] alu_result, store_data;
    logic       memwrite_o, memread_o, memtoreg_o, regwrite_o;
    logic [2:0] regwradd_o;

    int npass = 0;
    int nfail = 0;

    ex_stage_l3 #(.DATA_W(8), .RADDR_W(3)) dut (
        .clk2(clk2), .rst_n(rst_n), .in_valid(in_valid), .imm_in(imm_in),
        .a_in(a_in), .b_in(b_in), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .exmem_fwd(exmem_fwd), .memwb_fwd(memwb_fwd), .alusrc_in(alusrc_in),
        .alufn_in(alufn_in), .memwrite_in(memwrite_in), .memread_in(memread_in),
        .memtoreg_in(memtoreg_in), .regwrite_in(regwrite_in), .regwradd_in(regwradd_in),
        .flush(flush), .stall_o(stall_o), .out_valid(out_valid), .alu_result(alu_result),
        .store_data(store_data), .zero(zero), .memwrite_o(memwrite_o), .memread_o(memread_o),
        .memtoreg_o(memtoreg_o), .regwrite_o(regwrite_o), .regwradd_o(regwradd_o)
    );

    always #5 clk2 = ~clk2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk2);
        #1;
    endtask

    function automatic int pick(input int sel, input int r, input int ex, input int mw);
        if (sel == 1) return ex;
        if (sel == 2) return mw;
        return r;
    endfunction

    function automatic int sgn(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    function automatic int ref_alu(input int fn, input int a, input int b);
        case (fn)
            0: return (a + b) % 256;
            1: return (a - b + 256) % 256;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return (sgn(a) < sgn(b)) ? 1 : 0;
            6: return (a * (1 << (b % 8))) % 256;
`ifdef EX_MUL_EN
            default: return (a * b) % 256;
`else
            default: return 0;
`endif
        endcase
    endfunction

    task automatic set_op(input int fn, input int a, input int b, input bit src, input int imm);
        in_valid = 1'b1; alufn_in = 3'(fn); a_in = 8'(a); b_in = 8'(b);
        alusrc_in = src; imm_in = 8'(imm); fwd_a_sel = 2'd0; fwd_b_sel = 2'd0;
        exmem_fwd = 8'h33; memwb_fwd = 8'h44; flush = 1'b0;
        memwrite_in = 1'b0; memread_in = 1'b0; memtoreg_in = 1'b0;
        regwrite_in = 1'b1; regwradd_in = 3'($urandom_range(0, 7));
    endtask

    // Runs whatever is on the inputs from an idle stage through to its EX/MEM result.
    task automatic run_instr(input string tag);
        int  o1, fb, o2, exp, n_stall;
        bit  mw, mr, mt, rw;
        logic [2:0] rd;
        #1;
        o1  = pick(fwd_a_sel, a_in, exmem_fwd, memwb_fwd);
        fb  = pick(fwd_b_sel, b_in, exmem_fwd, memwb_fwd);
        o2  = alusrc_in ? int'(imm_in) : fb;
        exp = ref_alu(alufn_in, o1, o2);
        mw = memwrite_in; mr = memread_in; mt = memtoreg_in; rw = regwrite_in; rd = regwradd_in;
        if (flush || !in_valid) begin
            chk({tag, "_stall_bub"}, stall_o, 0);
            tick();
            chk({tag, "_bub_valid"}, out_valid, 0);
            chk({tag, "_bub_rw"}, regwrite_o, 0);
            chk({tag, "_bub_mw"}, memwrite_o, 0);
            return;
        end
        n_stall = 0;
`ifdef EX_MUL_EN
        if (alufn_in == 3'd7) n_stall = 8;
`endif
        for (int k = 0; k < n_stall; k++) begin
            chk({tag, "_mul_stall"}, stall_o, 1);
            tick();
            chk({tag, "_mul_bubble"}, out_valid, 0);
            exmem_fwd = 8'($urandom);
            memwb_fwd = 8'($urandom);
            #1;
        end
        chk({tag, "_stall"}, stall_o, 0);
        tick();
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_result"}, alu_result, exp);
        chk({tag, "_zero"}, zero, (exp == 0) ? 1 : 0);
        chk({tag, "_rw"}, regwrite_o, rw);
        chk({tag, "_mw"}, memwrite_o, mw);
        chk({tag, "_mr"}, memread_o, mr);
        chk({tag, "_mt"}, memtoreg_o, mt);
        chk({tag, "_rd"}, regwradd_o, rd);
        if (n_stall == 0) chk({tag, "_store"}, store_data, fb);
    endtask

    initial begin
        rst_n = 1'b0;
        set_op(0, 0, 0, 0, 0);
        in_valid = 1'b1;
        tick(); tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_result", alu_result, 0);
        chk("rst_store", store_data, 0);
        chk("rst_ctrl", {zero, memwrite_o, memread_o, memtoreg_o, regwrite_o}, 0);
        chk("rst_rd", regwradd_o, 0);
        chk("rst_stall", stall_o, 0);
        rst_n = 1'b1;

        set_op(0, 8'h7F, 8'h02, 0, 0);
        run_instr("add_7f_02");
        chk("add_7f_02_exact", alu_result, 8'h81);

        set_op(1, 8'h00, 8'h00, 0, 0);
        fwd_a_sel = 2'd1; fwd_b_sel = 2'd2; exmem_fwd = 8'd5; memwb_fwd = 8'd9;
        run_instr("sub_fwd");
        chk("sub_fwd_exact", alu_result, 8'hFC);

        set_op(0, 20, 3, 0, 0);
        fwd_b_sel = 2'd3; fwd_a_sel = 2'd3;
        run_instr("fwd_sel3");
        chk("fwd_sel3_exact", alu_result, 23);

        set_op(0, 8'hFF, 8'h01, 0, 0);
        run_instr("add_wrap_zero");

        set_op(7, 13, 11, 0, 0);
        run_instr("mul_13_11");
`ifdef EX_MUL_EN
        chk("mul_13_11_exact", alu_result, 8'h8F);
`else
        chk("mul_off_exact", alu_result, 0);
`endif
        set_op(0, 1, 2, 0, 0);
        run_instr("add_after_mul");

        set_op(0, 4, 4, 0, 0);
        flush = 1'b1;
        run_instr("flush_add");

`ifdef EX_MUL_EN
        set_op(7, 200, 3, 0, 0);
        #1 chk("fl_load_stall", stall_o, 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("fl_busy_stall", stall_o, 1);
        end
        flush = 1'b1;
        #1 chk("fl_stall_forced", stall_o, 0);
        tick();
        chk("fl_valid", out_valid, 0);
        chk("fl_rw", regwrite_o, 0);
        flush = 1'b0; a_in = 8'd7; b_in = 8'd6;
        run_instr("mul_restart");
        chk("mul_restart_exact", alu_result, 42);

        set_op(7, 9, 9, 0, 0);
        tick(); tick(); tick();
        rst_n = 1'b0; in_valid = 1'b0;
        #1 chk("mrst_stall", stall_o, 0);
        tick();
        chk("mrst_valid", out_valid, 0);
        chk("mrst_result", alu_result, 0);
        chk("mrst_ctrl", {zero, memwrite_o, memread_o, memtoreg_o, regwrite_o, regwradd_o}, 0);
        rst_n = 1'b1;
        #1 chk("mrst_idle_stall", stall_o, 0);
        tick();
        chk("mrst_idle_valid", out_valid, 0);
`endif

        set_op(5, 8'h80, 0, 1, 8'h01);
        run_instr("slt_neg");
        chk("slt_neg_exact", alu_result, 1);

        for (int i = 0; i < 60; i++) begin
            set_op($urandom_range(0, 7), $urandom, $urandom, 1'($urandom), $urandom);
            fwd_a_sel = 2'($urandom); fwd_b_sel = 2'($urandom);
            exmem_fwd = 8'($urandom); memwb_fwd = 8'($urandom);
            memwrite_in = 1'($urandom); memread_in = 1'($urandom);
            memtoreg_in = 1'($urandom); regwrite_in = 1'($urandom);
            in_valid = ($urandom_range(0, 7) != 0);
            flush = ($urandom_range(0, 9) == 0);
            run_instr("rand");
        end

        $display("%0d/%0d checks passed", npass, npass + nfail);
        $finish;
    end

endmodule
